adc_sampler: RTL and testbench

ADC_SAMPLER -- requirements
Module: adc_sampler

---
 rtl/adc_sampler_pkg.sv | 15 +
 rtl/adc_sampler_fifo.sv | 52 +++++
 rtl/adc_sampler.sv | 136 +++++++++++++
 tb/tb_adc_sampler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sampler_pkg.sv
// Shared types and widths for the ADC sampler: FSM state encoding,
// sample width and overrun counter width.
package adc_sampler_pkg;

  localparam int SAMPLE_W = 10;
  localparam int OVR_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_SETTLE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

endpackage

// File: rtl/adc_sampler_fifo.sv
// Synchronous sample FIFO with occupancy count; a push on a full FIFO is
// accepted only when a pop frees a slot in the same cycle, otherwise dropped.
module sample_fifo #(
  parameter  int DATA_W = 10,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full,
  output logic [LW-1:0]     level,
  output logic              drop
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;

  // Head reads as zero while empty so no stale storage leaks to the port.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/adc_sampler.sv
// Periodic MCP3002 sampler: tick timer, conversion FSM and sample FIFO.
// Optional macro ADC_SAMPLER_OVERRUN_CNT_EN enables the dropped-tick counter.
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int CLK_FREQ    = 27_000_000,
  parameter int SAMPLE_RATE = 50_000,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT     = 1023
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  output logic                        adc_enable,
  output logic                        adc_clear_available,
  input  logic                        adc_available,
  input  logic [SAMPLE_W-1:0]         adc_data,
  output logic [SAMPLE_W-1:0]         sample_data,
  output logic                        sample_valid,
  input  logic                        sample_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        timeout_err,
  output logic [OVR_W-1:0]            overrun_cnt
);

  localparam int TICK_PERIOD = CLK_FREQ / SAMPLE_RATE;
  localparam int TICK_W      = $clog2(TICK_PERIOD);
  localparam int WAIT_W      = $clog2(TIMEOUT + 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              push;
  logic              timeout_hit;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_drop;

  // Sample-rate timer: free-runs only while run is high.
  assign tick = run && (tick_cnt == TICK_W'(TICK_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (!run) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    adc_enable          = 1'b0;
    adc_clear_available = 1'b0;
    push                = 1'b0;
    timeout_hit         = 1'b0;
    unique case (state_q)
      S_IDLE: if (tick) state_d = S_START;
      S_START: begin
        adc_enable          = 1'b1;
        adc_clear_available = 1'b1;
        state_d             = S_SETTLE;
      end
      // The completion flag may still show the previous result this cycle.
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (adc_available) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counts completed WAIT cycles; TIMEOUT cycles in WAIT without completion abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= '0;
    else if (state_q == S_START) wait_cnt <= '0;
    else if (state_q == S_WAIT)  wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overflow    <= overflow | fifo_drop;
      timeout_err <= timeout_err | timeout_hit;
    end
  end

`ifdef ADC_SAMPLER_OVERRUN_CNT_EN
  logic drop_tick;
  assign drop_tick = tick && (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  overrun_cnt <= '0;
    else if (drop_tick && (overrun_cnt != '1))   overrun_cnt <= overrun_cnt + OVR_W'(1);
  end
`else
  assign overrun_cnt = '0;
`endif

  sample_fifo #(
    .DATA_W (SAMPLE_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (adc_data),
    .pop       (sample_ready),
    .head_data (sample_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  assign sample_valid = !fifo_empty;

  // Full is implied by the drop indication; kept on the FIFO for completeness.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler with a behavioural MCP3002 controller model.
`timescale 1ns/1ps
module tb_adc_sampler;

`ifdef ADC_SAMPLER_OVERRUN_CNT_EN
  localparam int OVR_ON = 1;
`else
  localparam int OVR_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       adc_enable;
  logic       adc_clear_available;
  logic       adc_available = 1'b0;
  logic [9:0] adc_data = '0;
  logic [9:0] sample_data;
  logic       sample_valid;
  logic       sample_ready = 1'b0;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       timeout_err;
  logic [7:0] overrun_cnt;

  int         conv_len = 480;
  bit         hang = 1'b0;
  logic [9:0] model_val = '0;
  int         mcnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adc_sampler dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .run                 (run),
    .adc_enable          (adc_enable),
    .adc_clear_available (adc_clear_available),
    .adc_available       (adc_available),
    .adc_data            (adc_data),
    .sample_data         (sample_data),
    .sample_valid        (sample_valid),
    .sample_ready        (sample_ready),
    .fifo_level          (fifo_level),
    .overflow            (overflow),
    .timeout_err         (timeout_err),
    .overrun_cnt         (overrun_cnt)
  );

  // MCP3002 controller model: conv_len cycles after the start pulse it raises
  // the sticky completion flag with model_val, unless hang is set.
  always @(posedge clk) begin
    if (adc_clear_available) adc_available <= 1'b0;
    if (adc_enable) mcnt <= conv_len;
    else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !hang) begin
        adc_available <= 1'b1;
        adc_data      <= model_val;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_en(input int budget, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (adc_enable === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_lvl(input int target, input int budget, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (fifo_level === 5'(target)) seen = 1'b1;
    end
  endtask

  initial begin
    int n;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_en", adc_enable, 0);
    check("rst_clr", adc_clear_available, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_ovr", overrun_cnt, 0);
    rst_n = 1'b1;

    // Periodic sampling, FIFO fill and overflow with the consumer stalled
    repeat (2) @(negedge clk);
    sample_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wait_en(1200, n, seen);
      check("en_seen", seen, 1);
      model_val = 10'h2A5 + 10'(i);
      if (i == 0) begin
        check("first_start", n, 540);
        check("clr_with_en", adc_clear_available, 1);
        @(negedge clk);
        check("en_one_cycle", adc_enable, 0);
        wait_lvl(1, 700, n, seen);
        check("lvl1_seen", seen, 1);
        check("push_latency", n, 481);
        check("first_data", sample_data, 10'h2A5);
        check("first_valid", sample_valid, 1);
      end else begin
        check("start_period", n, 58);
        if (i < 16) begin
          wait_lvl(i + 1, 700, n, seen);
          check("lvl_seen", seen, 1);
          check("push_latency", n, 482);
        end else begin
          check("full_level", fifo_level, 16);
          check("no_ovf_yet", overflow, 0);
          repeat (482) @(negedge clk);
          check("ovf_set", overflow, 1);
          check("full_level_kept", fifo_level, 16);
        end
      end
    end
    run = 1'b0;
    sample_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fifo_order", sample_data, 10'h2A5 + 10'(i));
      @(negedge clk);
    end
    check("drained_valid", sample_valid, 0);
    check("drained_level", fifo_level, 0);
    check("drained_data", sample_data, 0);
    check("ovf_sticky", overflow, 1);

    // Run dropped mid-conversion; push onto empty FIFO with ready held high
    model_val = 10'h1C7;
    @(negedge clk);
    run = 1'b1;
    wait_en(1200, n, seen);
    check("d_en_seen", seen, 1);
    check("d_start", n, 540);
    repeat (100) @(negedge clk);
    run = 1'b0;
    wait_lvl(1, 700, n, seen);
    check("d_lvl_seen", seen, 1);
    check("d_latency", n, 382);
    check("d_data", sample_data, 10'h1C7);
    @(negedge clk);
    check("d_popped", fifo_level, 0);
    wait_en(1500, n, seen);
    check("d_no_restart", seen, 0);

    // Slow conversions: one tick dropped per conversion
    conv_len = 600;
    model_val = 10'h3C3;
    @(negedge clk);
    run = 1'b1;
    wait_en(1200, n, seen);
    check("e_start", n, 540);
    wait_lvl(1, 800, n, seen);
    check("e_latency", n, 602);
    check("e_data", sample_data, 10'h3C3);
    model_val = 10'h0F0;
    wait_en(1200, n, seen);
    check("e_en_seen", seen, 1);
    check("e_period", n, 478);
    check("e_overrun", overrun_cnt, OVR_ON ? 1 : 0);
    run = 1'b0;
    wait_lvl(1, 800, n, seen);
    check("e_latency2", n, 602);
    check("e_data2", sample_data, 10'h0F0);

    // Controller never completes: timeout, then the next tick restarts
    conv_len = 480;
    hang = 1'b1;
    repeat (10) @(negedge clk);
    run = 1'b1;
    wait_en(1200, n, seen);
    check("f_start", n, 540);
    repeat (1024) @(negedge clk);
    check("f_tmo_before", timeout_err, 0);
    @(negedge clk);
    check("f_tmo_set", timeout_err, 1);
    check("f_overrun", overrun_cnt, OVR_ON ? 2 : 0);
    wait_en(200, n, seen);
    check("f_restart_seen", seen, 1);
    check("f_restart", n, 55);
    hang = 1'b0;
    model_val = 10'h155;
    run = 1'b0;
    wait_lvl(1, 700, n, seen);
    check("f_latency", n, 482);
    check("f_data", sample_data, 10'h155);
    check("f_tmo_sticky", timeout_err, 1);

    // Reset during S_WAIT abandons the conversion
    sample_ready = 1'b0;
    model_val = 10'h0AA;
    repeat (10) @(negedge clk);
    run = 1'b1;
    wait_en(1200, n, seen);
    check("g_start", n, 540);
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("g_rst_en", adc_enable, 0);
    check("g_rst_valid", sample_valid, 0);
    check("g_rst_level", fifo_level, 0);
    check("g_rst_data", sample_data, 0);
    check("g_rst_ovf", overflow, 0);
    check("g_rst_tmo", timeout_err, 0);
    check("g_rst_ovr", overrun_cnt, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    wait_en(1200, n, seen);
    check("g_restart", n, 540);
    check("g_no_push", fifo_level, 0);
    wait_lvl(1, 700, n, seen);
    check("g_latency", n, 482);
    check("g_data", sample_data, 10'h0AA);
    run = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
